if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage. Owns the architectural PC, fetches 32-bit instructions one byte at a time through a request/acknowledge handshake to the memory controller, and presents them to the IF_ID pipeline register. It is the consumer of the EX-stage redirect (`pcJump`/`pcTarget`): a taken jump or branch from EX aborts the fetch in progress and restarts fetching at the target.

## Interface
Parameters:
- `ADDR_W`, default 32: PC and memory address width.
- `INST_W`, default 32: instruction width; fetched as four bytes.
- `PC_STEP`, default 4: PC increment per accepted instruction.
- `ICACHE_LINES`, default 16: number of I-cache lines; must be a power of two. Used only when `IF_ICACHE_EN` is defined.

Ports:
- `clk_in` in 1: single clock; all state updates on the rising edge.
- `rstn_in` in 1: reset, asynchronous, active-low.
- `stall_in` in 1: downstream hazard stall; holds the presented instruction.
- `pcJump_in` in 1: redirect request from EX.
- `pcTarget_in` in ADDR_W: redirect target; used as-is, with no alignment check.
- `memReq_out` out 1: byte read request.
- `memAddr_out` out ADDR_W: byte address; stable while `memReq_out` is high.
- `memAck_in` in 1: one-cycle pulse; `memData_in` is valid in the same cycle.
- `memData_in` in 8: returned byte.
- `pc_out` out ADDR_W: PC of the presented instruction.
- `inst_out` out INST_W: the presented instruction.
- `instValid_out` out 1: `pc_out` and `inst_out` are valid.

## Operation
- **Reset:** all outputs are registered.
  - `pc` = 0x00000000; `pc_out`, `inst_out`, `memAddr_out` = 0.
  - `memReq_out`, `instValid_out` = 0.
  - State is IDLE, the byte counter is 0, and all cache valid bits are cleared.
- **State machine:**
  - IDLE → FETCH: on a cache miss, or always when the cache is compiled out. Set `memReq_out`=1 and `memAddr_out`=`pc`.
  - IDLE → VALID: on a cache hit. Load `inst_out` from the cache.
  - FETCH, on `memAck_in`: write `memData_in` into byte `cnt` of the assembly buffer (little-endian; byte 0 → bits [7:0]). Increment `cnt` and set `memAddr_out`=`pc`+`cnt`+1.
  - FETCH, ack with `cnt`==3: drop `memReq_out`, go to VALID, set `instValid_out`=1, and fill the cache line.
  - VALID, with `stall_in`=1: hold all outputs unchanged.
  - VALID, with `stall_in`=0: the instruction is accepted. Set `pc` += `PC_STEP`, `instValid_out`=0, and go to IDLE.
  - DRAIN: wait for `memAck_in`, discard its byte, drop `memReq_out`, and go to IDLE at the saved target.
- **Redirect:** `pcJump_in` has priority over `stall_in` and over acceptance.
  - Next edge: `pc` = `pcTarget_in`, `instValid_out` = 0, `cnt` = 0.
  - If `memReq_out` is high and `memAck_in` is low, go to DRAIN; the request stays asserted with the old address until it is acked.
  - Otherwise go to IDLE. A simultaneous ack is discarded.
  - A second redirect during DRAIN overwrites the saved target.
- **Arithmetic:** PC and address addition is modulo 2^ADDR_W and wraps silently (0xFFFFFFFC + 4 = 0).
- `memReq_out` never deasserts before an ack, except under reset.

## Timing
- **Miss latency:** `memReq_out` rises 1 cycle after IDLE. `instValid_out` rises on the edge that samples the 4th ack, so the minimum is 5 cycles from IDLE to valid with single-cycle acks.
- **Hit latency:** `instValid_out` is high 1 cycle after IDLE.
- **Throughput:**
  - Hits, with no stall: one instruction every 2 cycles (VALID → IDLE → VALID).
  - Misses: bound by memory.
- **Redirect:** fetch at the target begins at most 1 cycle after the pending ack, or 1 cycle after the redirect edge if no request is outstanding.
- **Reset mid-fetch:** takes effect immediately and asynchronously, including dropping `memReq_out`.

## Configuration
- `IF_ICACHE_EN` defined:
  - Direct-mapped cache of `ICACHE_LINES` entries, each holding a valid bit, a tag and an instruction.
  - Index = `pc`[2+log2(LINES)-1:2]; tag = the remaining upper bits.
  - Filled on every completed fetch; no invalidation except reset (no self-modifying code support).
- `IF_ICACHE_EN` undefined: no cache storage; IDLE always goes to FETCH.

## Structure
- **Shared defines package:**
  - Constants: `ZERO32`, `PCSTEP`, `Jump`/`NoJump`.
  - Active-low reset level constant.
  - Fetch state encoding: IDLE, FETCH, VALID, DRAIN.
- **Sub-module `if_icache`:** combinational lookup (hit flag and data); synchronous fill and clear. Instantiated only under `IF_ICACHE_EN`.

## Test plan
- **Reset then single fetch:** release reset; memory acks each request 1 cycle later with bytes 0x13, 0x00, 0x00, 0x00 → `memAddr_out` steps 0, 1, 2, 3; `inst_out`=0x00000013, `pc_out`=0, valid 5 cycles after IDLE.
- **Stall hold:** `stall_in`=1 for 3 cycles while valid → outputs are frozen and `pc` stays 0. Release `stall_in` → `pc`=4 and a fetch starts at address 4.
- **Redirect mid-fetch:** `pcJump_in`, target 0x100, while the byte-2 request is unacked → state is DRAIN with address 0x2 held. Ack it → the byte is discarded and the next request is at 0x100.
- **Redirect with simultaneous ack on byte 3:** the instruction is not presented and fetch resumes at the target.
- **Wrap:** `pc`=0xFFFFFFFC accepted → `pc`=0x00000000.
- **`IF_ICACHE_EN` loop:** a jump back to 0x0 after the first fetch → valid 1 cycle after IDLE, with no `memReq_out` asserted.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared constants and fetch state encoding for the instruction-fetch stage
package if_fetch_pkg;

  localparam logic [31:0] ZERO32 = 32'h0000_0000;
  localparam int unsigned PCSTEP = 4;
  localparam logic        Jump   = 1'b1;
  localparam logic        NoJump = 1'b0;
  localparam logic        RST_LVL = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - fetch-stage bundle: pipeline control, byte memory handshake, IF_ID outputs
interface if_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) ();
  logic              stall_in;
  logic              pcJump_in;
  logic [ADDR_W-1:0] pcTarget_in;
  logic              memReq_out;
  logic [ADDR_W-1:0] memAddr_out;
  logic              memAck_in;
  logic [7:0]        memData_in;
  logic [ADDR_W-1:0] pc_out;
  logic [INST_W-1:0] inst_out;
  logic              instValid_out;

  // Fetch unit side
  modport master (
    input  stall_in, pcJump_in, pcTarget_in, memAck_in, memData_in,
    output memReq_out, memAddr_out, pc_out, inst_out, instValid_out
  );

  // Pipeline / memory side
  modport slave (
    output stall_in, pcJump_in, pcTarget_in, memAck_in, memData_in,
    input  memReq_out, memAddr_out, pc_out, inst_out, instValid_out
  );
endinterface

// File: rtl/if_fetch_icache.sv
// rtl/if_fetch_icache.sv - direct-mapped instruction cache, combinational lookup, synchronous fill
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int LINES  = 16
) (
  input  logic              clk_in,
  input  logic              rstn_in,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [INST_W-1:0] rdata,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [INST_W-1:0] fill_data
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  logic [LINES-1:0] line_vld;
  logic [TAG_W-1:0] line_tag  [LINES];
  logic [INST_W-1:0] line_data [LINES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;

  assign rd_idx = lookup_addr[2 +: IDX_W];
  assign wr_idx = fill_addr[2 +: IDX_W];
  assign hit    = line_vld[rd_idx] && (line_tag[rd_idx] == lookup_addr[ADDR_W-1 -: TAG_W]);
  assign rdata  = line_data[rd_idx];

  // Valid bits are the only cache state cleared by reset
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (rstn_in == RST_LVL) begin
      line_vld <= '0;
    end else if (fill_en) begin
      line_vld[wr_idx] <= 1'b1;
    end
  end

  // Tag and instruction storage, written on every completed fetch
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      line_tag[wr_idx]  <= fill_addr[ADDR_W-1 -: TAG_W];
      line_data[wr_idx] <= fill_data;
    end
  end
endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage with byte-serial fetch and EX redirect; optional I-cache under IF_ICACHE_EN
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int          ADDR_W       = 32,
  parameter int          INST_W       = 32,
  parameter int unsigned PC_STEP      = PCSTEP,
  parameter int          ICACHE_LINES = 16
) (
  input logic         clk_in,
  input logic         rstn_in,
  if_fetch_if.master  bus
);
  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        cnt;
  logic [2:0][7:0]   asm_buf;
  logic [INST_W-1:0] fetched;
  logic              cache_hit;
  logic [INST_W-1:0] cache_data;

  // Last byte arrives straight from memory, the first three from the assembly buffer
  assign fetched = {bus.memData_in, asm_buf};

  if ((ICACHE_LINES < 1) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_lines_check
    $error("ICACHE_LINES must be a power of two");
  end

`ifdef IF_ICACHE_EN
  logic fill_en;

  assign fill_en = (state == FETCH) && bus.memAck_in && (cnt == 2'd3) && (bus.pcJump_in != Jump);

  if_icache #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .LINES  (ICACHE_LINES)
  ) u_icache (
    .clk_in      (clk_in),
    .rstn_in     (rstn_in),
    .lookup_addr (pc),
    .hit         (cache_hit),
    .rdata       (cache_data),
    .fill_en     (fill_en),
    .fill_addr   (pc),
    .fill_data   (fetched)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // Fetch FSM; a redirect overrides stall and acceptance, and an outstanding request is drained first
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (rstn_in == RST_LVL) begin
      state             <= IDLE;
      pc                <= ADDR_W'(ZERO32);
      cnt               <= 2'd0;
      asm_buf           <= '0;
      bus.memReq_out    <= 1'b0;
      bus.memAddr_out   <= '0;
      bus.pc_out        <= '0;
      bus.inst_out      <= '0;
      bus.instValid_out <= 1'b0;
    end else if (bus.pcJump_in == Jump) begin
      pc                <= bus.pcTarget_in;
      bus.instValid_out <= 1'b0;
      cnt               <= 2'd0;
      if (bus.memReq_out && !bus.memAck_in) begin
        state <= DRAIN;
      end else begin
        state          <= IDLE;
        bus.memReq_out <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cache_hit) begin
            state             <= VALID;
            bus.inst_out      <= cache_data;
            bus.pc_out        <= pc;
            bus.instValid_out <= 1'b1;
          end else begin
            state           <= FETCH;
            cnt             <= 2'd0;
            bus.memReq_out  <= 1'b1;
            bus.memAddr_out <= pc;
          end
        end
        FETCH: begin
          if (bus.memAck_in) begin
            if (cnt == 2'd3) begin
              state             <= VALID;
              cnt               <= 2'd0;
              bus.memReq_out    <= 1'b0;
              bus.inst_out      <= fetched;
              bus.pc_out        <= pc;
              bus.instValid_out <= 1'b1;
            end else begin
              asm_buf[cnt]    <= bus.memData_in;
              cnt             <= cnt + 2'd1;
              bus.memAddr_out <= pc + ADDR_W'(cnt) + ADDR_W'(1);
            end
          end
        end
        VALID: begin
          if (!bus.stall_in) begin
            state             <= IDLE;
            pc                <= pc + ADDR_W'(PC_STEP);
            bus.instValid_out <= 1'b0;
          end
        end
        DRAIN: begin
          if (bus.memAck_in) begin
            state          <= IDLE;
            bus.memReq_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
